// File: rtl/pulse_stretch_if.sv
// Event/indicator signal bundle for pulse_stretch: master issues event pulses,
// slave (the stretcher) reports indicator, status and queue depth.
interface pulse_stretch_if #(
    parameter int unsigned PEND_W = 3
);
    logic              pulse;
    logic              clr_ovf;
    logic              led;
    logic              busy;
    logic              done;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output pulse, clr_ovf,
        input  led, busy, done, pending, overflow
    );

    modport slave (
        input  pulse, clr_ovf,
        output led, busy, done, pending, overflow
    );
endinterface

// File: rtl/pulse_stretch.sv
// Stretches single-cycle event pulses into timed LED blinks separated by a fixed gap.
// Define PULSE_STRETCH_QUEUE_EN to queue events arriving mid-blink; otherwise they are dropped.
module pulse_stretch #(
    parameter int unsigned HOLD_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 12500000,
    parameter int unsigned CNT_W       = 25,
    parameter int unsigned PEND_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    pulse_stretch_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

    localparam logic [CNT_W-1:0]  HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_RELOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX    = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               can_start, start, drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pend_d    = pend_q;
        drop      = 1'b0;
        can_start = (state_q == S_IDLE) || (state_q == S_GAP && timer_q == '0);
        start     = can_start && (bus.pulse || pend_q != '0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ON;
                    timer_d = HOLD_RELOAD;
                end
            end
            S_ON: begin
                if (timer_q == '0) begin
                    state_d = S_GAP;
                    timer_d = GAP_RELOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_GAP: begin
                if (timer_q == '0) begin
                    state_d = start ? S_ON : S_IDLE;
                    timer_d = start ? HOLD_RELOAD : timer_q;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

`ifdef PULSE_STRETCH_QUEUE_EN
        // A start with a queued event consumes the queue; a coincident pulse refills it.
        if (start && pend_q != '0) begin
            if (!bus.pulse)
                pend_d = pend_q - 1'b1;
        end else if (bus.pulse && !start) begin
            if (pend_q == PEND_MAX)
                drop = 1'b1;
            else
                pend_d = pend_q + 1'b1;
        end
`else
        pend_d = '0;
        drop   = bus.pulse && !start;
`endif

        if (drop)
            ovf_d = 1'b1;
        else if (bus.clr_ovf)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;

        led_d  = (state_d == S_ON);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_ON) && (timer_d == '0);
    end

    assign bus.led      = led_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pending  = pend_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch: directed scenarios plus random traffic,
// compared against a blink-schedule model (start edge, next-free edge, queue count).
module tb_pulse_stretch;
    localparam int unsigned H    = 4;
    localparam int unsigned G    = 2;
    localparam int unsigned PW   = 2;
    localparam int          PMAX = (1 << PW) - 1;
`ifdef PULSE_STRETCH_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pulse_stretch_if #(.PEND_W(PW)) bus ();

    pulse_stretch #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .CNT_W      (4),
        .PEND_W     (PW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Schedule model: blink_s = edge the current/last blink started,
    // avail = first edge at which a new blink may start.
    int edge_n  = 0;
    int blink_s = -1000;
    int avail   = 0;
    int m_pend  = 0;
    bit m_ovf   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("led",      32'(bus.led),      32'(edge_n >= blink_s && edge_n < blink_s + int'(H)));
        check("done",     32'(bus.done),     32'(edge_n == blink_s + int'(H) - 1));
        check("busy",     32'(bus.busy),     32'(edge_n < avail));
        check("pending",  32'(bus.pending),  32'(m_pend));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic model_reset();
        blink_s = -1000;
        avail   = 0;
        m_pend  = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input bit pl, input bit clr);
        bit dropped;
        dropped = 1'b0;
        if (edge_n >= avail && (pl || m_pend > 0)) begin
            blink_s = edge_n;
            avail   = edge_n + int'(H) + int'(G);
            if (m_pend > 0 && !pl)
                m_pend--;
        end else if (pl) begin
            if (QEN && m_pend < PMAX)
                m_pend++;
            else
                dropped = 1'b1;
        end
        if (dropped)
            m_ovf = 1'b1;
        else if (clr)
            m_ovf = 1'b0;
    endtask

    task automatic cycle(input bit pl, input bit clr);
        bus.pulse   = pl;
        bus.clr_ovf = clr;
        @(posedge clk);
        edge_n++;
        model_edge(pl, clr);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bus.pulse   = 1'b0;
        bus.clr_ovf = 1'b0;
        reset       = 1'b0;
        #12;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b1;

        // Single blink
        cycle(1'b1, 1'b0);
        idle(10);

        // Three pulses one cycle apart
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        idle(25);

        // Saturation, clear coincident with a drop, then clear alone
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        idle(35);

        // Pulse on the last gap cycle with one event queued
        cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
        idle(4);
        cycle(1'b1, 1'b0);
        idle(25);

        // Reset mid-blink with a queue, then a normal blink
        cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        async_reset();
        cycle(1'b1, 1'b0);
        idle(10);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0)
                async_reset();
            else
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end
        idle(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Output-side counterpart to the button input conditioning.
- Accepts single-cycle event pulses from the vending-machine control FSM, e.g. dispense, coin accepted, change returned.
- Drives a human-visible indicator: each accepted pulse becomes one timed "on" interval followed by a mandatory "off" gap.
- Pulses that arrive while a blink is in progress are queued in a saturating counter, so N events always produce N distinct blinks, up to the queue depth.

Parameters:
- HOLD_CYCLES, 25000000: clock cycles `led` stays high per blink (0.5 s at 50 MHz); legal range 1 to 2^CNT_W.
- GAP_CYCLES, 12500000: clock cycles `led` stays low between queued blinks; legal range 1 to 2^CNT_W.
- CNT_W, 25: width of the interval timer.
- PEND_W, 3: width of the pending counter; maximum queued events = 2^PEND_W-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- pulse  input  1  event request; one-cycle pulse, sampled on posedge clk
- clr_ovf  input  1  synchronous clear of `overflow`
- led  output  1  stretched indicator output, registered
- busy  output  1  high in ON or GAP state
- done  output  1  one-cycle pulse on the last cycle of each ON interval
- pending  output  PEND_W  events waiting for a blink, excluding the one currently shown
- overflow  output  1  sticky; set when a pulse is dropped

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, timer=0, led=0, busy=0, done=0, pending=0, overflow=0. Reset mid-blink aborts the blink immediately; queued events are lost.
- All outputs are registered. State encoding: IDLE, ON, GAP.
- Start condition `start`: (state==IDLE, or state==GAP with timer==0) AND (pulse==1 or pending!=0).
- Start with pending==0 consumes `pulse` directly.
- Start with pending!=0 consumes one queued event; a simultaneous `pulse` is queued, so pending is unchanged.
- IDLE:
  - On `start`, go to ON, led=1, timer=HOLD_CYCLES-1.
  - Latency: pulse sampled at edge t gives led=1 after edge t.
- ON:
  - timer decrements each cycle.
  - done=1 during the cycle in which timer==0.
  - At that edge, go to GAP, led=0, timer=GAP_CYCLES-1.
  - led is therefore high for exactly HOLD_CYCLES cycles.
- GAP:
  - timer decrements each cycle.
  - At timer==0: if `start`, go to ON as in IDLE; otherwise go to IDLE.
  - led is therefore low for exactly GAP_CYCLES cycles between blinks. No two blinks ever merge.
- Queueing: a pulse that does not cause a start increments pending.
- Saturation: if pending==2^PEND_W-1 and the pulse is not consumed, pending holds, the pulse is dropped, and overflow is set.
- Overflow priority: set beats clr_ovf in the same cycle.
- busy = (state!=IDLE). busy is low for at least one cycle only when pending==0 at the end of GAP.
- Timer arithmetic: unsigned CNT_W-bit; the HOLD/GAP reload values are truncated to CNT_W bits.
- Never dependent on `pulse` width: a level held high for K cycles is K events. Callers must supply one-cycle pulses.

Optional Feature:
- Macro: PULSE_STRETCH_QUEUE_EN.
- Defined: queueing as described above.
- Not defined:
  - pending is tied to 0.
  - Any pulse that does not cause a start (i.e. arrives during ON, or during GAP before timer==0) is dropped and sets overflow.
  - All other behaviour is identical.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=2, PEND_W=2, queue enabled unless noted):
- Single pulse in IDLE at edge 0 -> led=1 after edges 0..3 (4 cycles); done=1 in the 4th high cycle; led=0 for 2 cycles; then IDLE with busy=0 and pending=0.
- Three pulses 1 cycle apart -> pending rises to 2; 3 blinks of 4 high/2 low, back-to-back with no IDLE between; 3 done pulses; overflow=0.
- Five pulses during one blink -> pending saturates at 3; overflow=1; 4 blinks in total. clr_ovf=1 then clears overflow. clr_ovf coincident with a drop leaves overflow=1.
- Pulse exactly on the last GAP cycle with pending=1 -> next blink starts at that edge; pending stays 1.
- Assert reset (0) mid-ON with pending=2 -> led, busy, pending and overflow all 0 immediately, without waiting for a clk edge. Release reset, then one pulse -> normal single blink.
- PULSE_STRETCH_QUEUE_EN undefined, two pulses 2 cycles apart -> exactly one blink; overflow=1; pending stays 0.
